pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx_pkg.sv | 23 ++
 rtl/pattern_tx_shreg.sv | 47 ++++
 rtl/pattern_tx.sv | 133 +++++++++++++
 tb/tb_pattern_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// pattern_tx shared types: FSM state encoding, default parameters and
// the counter-width helper. Parity state is used only with PATTERN_TX_PARITY_EN.
package pattern_tx_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int GAP_DEF   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pattern_tx_shreg.sv
// pattern_tx_shreg: loadable MSB-first shift register; msb feeds dout.
// With PATTERN_TX_PARITY_EN it also keeps the even parity of the loaded word.
module pattern_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic             fill,
    input  logic [WIDTH-1:0] data_in,
`ifdef PATTERN_TX_PARITY_EN
    output logic             parity,
`endif
    output logic             msb
);

    logic [WIDTH-1:0] q;

    // Clear wins over load, load over shift; fill enters at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= data_in;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], fill};
        end
    end

`ifdef PATTERN_TX_PARITY_EN
    // Parity is frozen at load so later shifts cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^data_in;
        end
    end
`endif

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serializes a WIDTH-bit pattern MSB first, then idles GAP cycles.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit to each frame.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             done
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam state_t AFTER = (GAP > 0) ? ST_GAP : ST_IDLE;
    localparam logic AFTER_RDY = (GAP == 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    gcnt;
    logic          accept;
    logic          shift;
    logic          clear;
    logic          fill;

    assign accept = (state == ST_IDLE) && ready && valid && !abort;
    assign shift  = (state == ST_SHIFT) && !abort;

`ifdef PATTERN_TX_PARITY_EN
    logic parity;
    assign fill  = parity;
    assign clear = ((state != ST_IDLE) && abort) || (state == ST_PAR);
`else
    assign fill  = 1'b0;
    assign clear = (state != ST_IDLE) && abort;
`endif

    pattern_tx_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (shift),
        .clear  (clear),
        .fill   (fill),
        .data_in(data_in),
`ifdef PATTERN_TX_PARITY_EN
        .parity (parity),
`endif
        .msb    (dout)
    );

    // Frame sequencer: accept, count bits, optional parity, gap, abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            gcnt       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state != ST_IDLE) && abort) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                gcnt       <= '0;
                dout_valid <= 1'b0;
                ready      <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state      <= ST_SHIFT;
                            cnt        <= '0;
                            dout_valid <= 1'b1;
                            ready      <= 1'b0;
                        end else begin
                            ready <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (cnt == LAST) begin
                            cnt <= '0;
`ifdef PATTERN_TX_PARITY_EN
                            state <= ST_PAR;
`else
                            state      <= AFTER;
                            gcnt       <= '0;
                            dout_valid <= 1'b0;
                            done       <= 1'b1;
                            ready      <= AFTER_RDY;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef PATTERN_TX_PARITY_EN
                    ST_PAR: begin
                        state      <= AFTER;
                        gcnt       <= '0;
                        dout_valid <= 1'b0;
                        done       <= 1'b1;
                        ready      <= AFTER_RDY;
                    end
`endif
                    ST_GAP: begin
                        if (gcnt == GAP_LAST) begin
                            state <= ST_IDLE;
                            gcnt  <= '0;
                            ready <= 1'b1;
                        end else begin
                            gcnt <= gcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed vector table on a GAP=1 instance plus hand
// sequences for back-to-back (GAP=0 instance) and async reset mid-frame.
module tb_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       valid = 1'b0;
    logic       abort = 1'b0;
    logic       ready, dout, dout_valid, done;

    logic [7:0] data0 = '0;
    logic       valid0 = 1'b0;
    logic       abort0 = 1'b0;
    logic       ready0, dout0, dout_valid0, done0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pattern_tx #(.WIDTH(8), .GAP(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready), .abort(abort), .dout(dout),
        .dout_valid(dout_valid), .done(done)
    );

    pattern_tx #(.WIDTH(8), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data0), .valid(valid0),
        .ready(ready0), .abort(abort0), .dout(dout0),
        .dout_valid(dout_valid0), .done(done0)
    );

    typedef struct {
        logic       valid;
        logic       abort;
        logic [7:0] data;
        logic       dout;
        logic       dv;
        logic       rdy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic a, input logic [7:0] d,
                       input logic o, input logic dv, input logic r,
                       input logic dn);
        vec_t e;
        e.valid = v; e.abort = a; e.data = d;
        e.dout = o; e.dv = dv; e.rdy = r; e.done = dn;
        tbl.push_back(e);
    endtask

    // One full frame on the GAP=1 instance; data_in is scrambled after
    // acceptance and valid stays high so neither may disturb the frame.
    task automatic frame(input logic [7:0] d, input logic p, input logic [7:0] n);
        add(1'b1, 1'b0, d, d[7], 1'b1, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--)
            add(1'b1, 1'b0, n ^ 8'(i), d[i], 1'b1, 1'b0, 1'b0);
`ifdef PATTERN_TX_PARITY_EN
        add(1'b1, 1'b0, ~n, p, 1'b1, 1'b0, 1'b0);
`else
        if (p !== 1'bx) add(1'b0, 1'b0, n, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
`ifdef PATTERN_TX_PARITY_EN
        add(1'b0, 1'b0, n, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        add(1'b1, 1'b0, ~d, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst dout", dout, 1'b0);
        chk("rst dout_valid", dout_valid, 1'b0);
        chk("rst ready", ready, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst ready0", ready0, 1'b0);
        #3 rst = 1'b0;

        // vector table
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(8'b1011_0010, 1'b0, 8'h00);
        frame(8'h3C, 1'b0, 8'hC3);
        frame(8'hA5, 1'b0, 8'h5A);
        frame(8'h07, 1'b1, 8'hF8);
        // abort on the 4th shift cycle of 8'hF0
        add(1'b1, 1'b0, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        // abort in IDLE blocks acceptance
        add(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        foreach (tbl[j]) begin
            valid = tbl[j].valid;
            abort = tbl[j].abort;
            data_in = tbl[j].data;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d dout", j), dout, tbl[j].dout);
            chk($sformatf("row%0d dout_valid", j), dout_valid, tbl[j].dv);
            chk($sformatf("row%0d ready", j), ready, tbl[j].rdy);
            chk($sformatf("row%0d done", j), done, tbl[j].done);
        end
        valid = 1'b0;
        abort = 1'b0;

        // back-to-back on GAP=0: 8'hFF then 8'h00 with valid held
        valid0 = 1'b1;
        data0 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("b2b ones dout", dout0, 1'b1);
            chk("b2b ones dv", dout_valid0, 1'b1);
            if (i == 0) data0 = 8'h00;
        end
`ifdef PATTERN_TX_PARITY_EN
        @(posedge clk);
        #1;
        chk("b2b par0 dout", dout0, 1'b0);
        chk("b2b par0 dv", dout_valid0, 1'b1);
`endif
        @(posedge clk);
        #1;
        chk("b2b idle done", done0, 1'b1);
        chk("b2b idle dv", dout_valid0, 1'b0);
        chk("b2b idle ready", ready0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("b2b zeros dout", dout0, 1'b0);
            chk("b2b zeros dv", dout_valid0, 1'b1);
            chk("b2b zeros done", done0, 1'b0);
            valid0 = 1'b0;
        end
`ifdef PATTERN_TX_PARITY_EN
        @(posedge clk);
        #1;
        chk("b2b par1 dv", dout_valid0, 1'b1);
`endif
        @(posedge clk);
        #1;
        chk("b2b end done", done0, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b after done", done0, 1'b0);
        chk("b2b after ready", ready0, 1'b1);

        // async reset mid-frame
        valid = 1'b1;
        data_in = 8'hFF;
        @(posedge clk);
        #1;
        chk("arst start dv", dout_valid, 1'b1);
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("arst pre dout", dout, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("arst dout", dout, 1'b0);
        chk("arst dv", dout_valid, 1'b0);
        chk("arst ready", ready, 1'b0);
        chk("arst done", done, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst rel ready", ready, 1'b1);
        chk("arst rel dv", dout_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("arst no done", done, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
